data_memory: RTL and testbench
==============================

# data_memory

Word-organised data memory that answers the core's load/store port: it is the responder on the same four-byte-lane `mem_addr` / `mem_data_in` / `mem_data_out` / `mem_write_en` interface the core drives. It adds a `mem_req` / `mem_ready` handshake and a parameterised access latency, so the cache-miss path in the controller can be exercised against realistic memory timing. It sits outside the core, between the core's memory port and the testbench top.

## Interface
- `DEPTH_WORDS`, 16384, number of 32-bit words (power of two; 64 KiB default).
- `LATENCY`, 4, cycles from request acceptance to `mem_ready` (integer, ≥ 1).

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req`  in  1  request strobe; sampled only in IDLE.
- `mem_addr`  in  32  byte address of the access.
- `mem_write_en`  in  1  1 = store, 0 = load; captured with the request.
- `mem_data_in`  in  8 × [0:3]  store data; lane 0 = least-significant byte.
- `mem_data_out`  out  8 × [0:3]  load data; lane 0 = least-significant byte.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_busy`  out  1  high while an access is in flight.
- `mem_error`  out  1  misaligned-request pulse (present only with `DATA_MEM_ALIGN_CHECK_EN`).

## Operation
- Byte order is little-endian. Lane k maps to byte address word_base + k.
- Word index is `mem_addr[2 +: log2(DEPTH_WORDS)]`. Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS × 4.
- State machine:
  - IDLE → BUSY when `mem_req` = 1. Address, write enable and data are latched, and the counter is loaded with LATENCY−1.
  - BUSY holds while the counter is non-zero, decrementing once per cycle.
  - BUSY → DONE when the counter reaches 0. A store writes all four lanes into the array; a load registers the word into `mem_data_out`.
  - DONE → IDLE unconditionally.
- `mem_req` in BUSY or DONE is ignored. It is neither queued nor an error.
- `mem_data_out` holds its last load value until the next load completes. Stores do not change it.
- A store followed by a load to the same address returns the new data.
- Storage array contents are not initialised and not cleared by reset.

## Timing
- Request accepted at edge N. `mem_busy` = 1 from cycle N+1 through the DONE cycle inclusive.
- `mem_ready` = 1 for exactly one cycle, cycle N+LATENCY, i.e. the DONE state.
  - Load data is valid in the same cycle.
  - A store's write is visible to a request accepted at edge N+LATENCY+1 or later.
- The earliest next acceptance is the edge ending the DONE cycle, when the state is IDLE with `mem_req` = 1. Maximum throughput is one access per LATENCY+1 cycles.
- LATENCY = 1: BUSY is skipped (IDLE → DONE), ready at N+1.
- Reset values: state IDLE, counter 0, `mem_ready` 0, `mem_busy` 0, `mem_error` 0, `mem_data_out` all lanes 0x00.
- `rst` asserted mid-access aborts it. A pending store is discarded (array unchanged), and no `mem_ready` pulse is produced.
- `rst` and `mem_req` in the same cycle: reset wins, and the request is dropped.

## Configuration
- `DATA_MEM_ALIGN_CHECK_EN` defined:
  - A request with `mem_addr[1:0]` ≠ 0 is accepted (goes to BUSY, full latency) but completes with `mem_error` = 1 alongside `mem_ready`.
  - A store is suppressed; a load leaves `mem_data_out` unchanged.
- Not defined:
  - `mem_error` port is absent and `mem_addr[1:0]` is ignored.
  - Misaligned accesses hit the containing word.

## Structure
- Shared package `mem_pkg`:
  - state enum `mem_state_t` {IDLE, BUSY, DONE};
  - typedef `byte_lanes_t` (four 8-bit lanes);
  - constant `WORD_BYTES` = 4.
- Sub-module `mem_array`: single-port synchronous word store with `DEPTH_WORDS` entries, a write enable and a registered read. `data_memory` owns the FSM, counter, capture registers and `mem_error`.

## Test plan
- Store/load: LATENCY=4; store 0xDEADBEEF at 0x10 → `mem_ready` at N+4. Load 0x10 → lanes 0..3 = EF, BE, AD, DE at its ready cycle; `mem_busy` high for 4 cycles each access.
- Busy rejection: load at 0x20 accepted; `mem_req` held high with a store to 0x20 during BUSY → ignored. A second pulse occurs only after re-acceptance from IDLE; `mem_data_out` is unaffected by the ignored request.
- Reset mid-store: store 0x11223344 to 0x30 with `rst` at N+2 → no `mem_ready`, all outputs 0. A later load of 0x30 returns the prior contents (preload 0xCAFEF00D).
- Alias wrap: DEPTH_WORDS=16; store 0xA5A5A5A5 at 0x44 → load at 0x04 returns 0xA5A5A5A5.
- LATENCY=1 back-to-back: `mem_req` held high for 4 cycles with alternating store/load to 0x0 → ready every 2nd cycle, load returns the just-stored word.
- With `DATA_MEM_ALIGN_CHECK_EN`: store at 0x12 → `mem_error` and `mem_ready` together at N+LATENCY; a load of 0x10 shows the word unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the data memory: FSM states, byte-lane word type, word width.
// Combinational helpers only; no latency or flow control of its own.
package mem_pkg;

    localparam int WORD_BYTES = 4;

    // Lane 0 is the least-significant byte (little-endian word).
    typedef logic [WORD_BYTES-1:0][7:0] byte_lanes_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return |addr_lsbs;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Core load/store port bundle; master = core side, slave = data memory.
// mem_error exists only when DATA_MEM_ALIGN_CHECK_EN is defined.
interface data_memory_if;
    import mem_pkg::*;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    byte_lanes_t mem_data_in;
    byte_lanes_t mem_data_out;
    logic        mem_ready;
    logic        mem_busy;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic        mem_error;
`endif

    modport master (
        output mem_req,
        output mem_addr,
        output mem_write_en,
        output mem_data_in,
`ifdef DATA_MEM_ALIGN_CHECK_EN
        input  mem_error,
`endif
        input  mem_data_out,
        input  mem_ready,
        input  mem_busy
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_write_en,
        input  mem_data_in,
`ifdef DATA_MEM_ALIGN_CHECK_EN
        output mem_error,
`endif
        output mem_data_out,
        output mem_ready,
        output mem_busy
    );

endinterface

// File: rtl/mem_array.sv
// Single-port word store with registered read; read data register clears on rst.
// Latency: 1 cycle read. No backpressure: one access per enabled cycle.
// Array contents are never initialised or cleared.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  byte_lanes_t      wr_dat,
    output byte_lanes_t      rd_dat
);

    byte_lanes_t mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wr_dat;
        end
    end

    // Read register holds its value across stores and idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat <= '0;
        end else if (en && !we) begin
            rd_dat <= mem[idx];
        end
    end

endmodule

// File: rtl/data_memory.sv
// Word data memory behind the core load/store port with req/ready handshake.
// Latency: LATENCY cycles from acceptance to a one-cycle mem_ready; one access in flight.
// Requests outside IDLE are ignored; DATA_MEM_ALIGN_CHECK_EN adds misaligned-access mem_error.
module data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 4
) (
    input  logic         clk,
    input  logic         rst,
    data_memory_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    mem_state_t       state_q;
    mem_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             capture;
    logic             finish;

    logic [IDX_W-1:0] idx_q;
    logic             we_q;
    byte_lanes_t      dat_q;
    logic             mis_q;

    logic [IDX_W-1:0] acc_idx;
    logic             acc_we;
    byte_lanes_t      acc_dat;
    logic             acc_mis;
    logic             req_mis;
    logic             arr_en;
    byte_lanes_t      rd_dat;
    logic             unused_addr;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign req_mis = is_misaligned(bus.mem_addr[1:0]);
`else
    assign req_mis = 1'b0;
`endif

    // Without the alignment check the low bits select nothing; the upper bits alias.
    assign unused_addr = ^{bus.mem_addr[31:2+IDX_W], bus.mem_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The array access happens on the edge entering DONE so load data is
    // registered in time for mem_ready; with LATENCY=1 that is the accept edge
    // itself, so the live request fields are used instead of the captured ones.
    always_comb begin
        if (state_q == IDLE) begin
            acc_idx = bus.mem_addr[2 +: IDX_W];
            acc_we  = bus.mem_write_en;
            acc_dat = bus.mem_data_in;
            acc_mis = req_mis;
        end else begin
            acc_idx = idx_q;
            acc_we  = we_q;
            acc_dat = dat_q;
            acc_mis = mis_q;
        end
    end

    assign arr_en = finish && !acc_mis && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q <= bus.mem_addr[2 +: IDX_W];
                we_q  <= bus.mem_write_en;
                dat_q <= bus.mem_data_in;
                mis_q <= req_mis;
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .en     (arr_en),
        .we     (acc_we),
        .idx    (acc_idx),
        .wr_dat (acc_dat),
        .rd_dat (rd_dat)
    );

    assign bus.mem_data_out = rd_dat;
    assign bus.mem_ready    = (state_q == DONE);
    assign bus.mem_busy     = (state_q != IDLE);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign bus.mem_error    = (state_q == DONE) && mis_q;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: LATENCY=4 instance with random traffic plus a LATENCY=1 back-to-back instance.
`timescale 1ns/1ps
module tb_data_memory;
    import mem_pkg::*;

    localparam int L0 = 4;
    localparam int D0 = 16;
    localparam int L1 = 1;
    localparam int D1 = 16;
    localparam int IW = $clog2(D0);

    typedef struct {
        int          due;
        bit          is_load;
        bit          err;
        logic [31:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model [D0];
    logic [31:0] exp_dout0;
    logic [31:0] exp_dout1;

    data_memory_if mif ();
    data_memory_if mif1 ();

    data_memory #(.DEPTH_WORDS(D0), .LATENCY(L0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    data_memory #(.DEPTH_WORDS(D1), .LATENCY(L1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (mif1.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One access on the LATENCY=4 port; called one cycle into IDLE, returns one cycle into IDLE.
    task automatic access0(input logic we, input logic [31:0] addr, input logic [31:0] dat,
                           input logic noise, input logic n_we, input logic [31:0] n_addr,
                           input logic [31:0] n_dat);
        exp_t e;
        logic got;
        mif.mem_req      = 1'b1;
        mif.mem_write_en = we;
        mif.mem_addr     = addr;
        mif.mem_data_in  = dat;
        @(posedge clk); #1;
        e.due     = cyc + L0 - 1;
        e.is_load = !we;
        e.err     = 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
        e.err     = (addr[1:0] != 2'b00);
`endif
        e.dat     = model[addr[2 +: IW]];
        if (we && !e.err) model[addr[2 +: IW]] = dat;
        q0.push_back(e);
        if (noise) begin
            mif.mem_write_en = n_we;
            mif.mem_addr     = n_addr;
            mif.mem_data_in  = n_dat;
        end else begin
            mif.mem_req = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < L0 + 4 && !got; k++) begin
            @(negedge clk);
            got = mif.mem_ready;
        end
        check_bit("ready_seen", got, 1'b1);
        @(posedge clk); #1;
        mif.mem_req = 1'b0;
    endtask

    initial begin : mon0
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q0.delete();
                exp_dout0 = '0;
            end else begin
                check_bit("busy", mif.mem_busy, q0.size() != 0);
                if (q0.size() == 0) begin
                    check_bit("ready_idle", mif.mem_ready, 1'b0);
`ifdef DATA_MEM_ALIGN_CHECK_EN
                    check_bit("error_idle", mif.mem_error, 1'b0);
`endif
                end else if (mif.mem_ready || cyc >= q0[0].due) begin
                    e = q0.pop_front();
                    check_bit("ready", mif.mem_ready, 1'b1);
                    check("ready_cycle", cyc, e.due);
`ifdef DATA_MEM_ALIGN_CHECK_EN
                    check_bit("error", mif.mem_error, e.err);
`endif
                    if (mif.mem_ready && e.is_load && !e.err) exp_dout0 = e.dat;
                end
                check("dout", mif.mem_data_out, exp_dout0);
            end
        end
    end

    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q1.delete();
                exp_dout1 = '0;
            end else begin
                check_bit("l1_busy", mif1.mem_busy, q1.size() != 0);
                if (q1.size() == 0) begin
                    check_bit("l1_ready_idle", mif1.mem_ready, 1'b0);
                end else if (mif1.mem_ready || cyc >= q1[0].due) begin
                    e = q1.pop_front();
                    check_bit("l1_ready", mif1.mem_ready, 1'b1);
                    check("l1_ready_cycle", cyc, e.due);
                    if (mif1.mem_ready && e.is_load) exp_dout1 = e.dat;
                end
                check("l1_dout", mif1.mem_data_out, exp_dout1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0]  want [4];
        logic [31:0] d;
        exp_t        e;
        rst = 1'b1;
        mif.mem_req = 1'b0;  mif.mem_write_en = 1'b0;  mif.mem_addr = '0;  mif.mem_data_in = '0;
        mif1.mem_req = 1'b0; mif1.mem_write_en = 1'b0; mif1.mem_addr = '0; mif1.mem_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_bit("rst_busy", mif.mem_busy, 1'b0);
        check_bit("rst_ready", mif.mem_ready, 1'b0);
        check("rst_dout", mif.mem_data_out, 32'h0);
        check("rst_dout_l1", mif1.mem_data_out, 32'h0);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        check_bit("rst_error", mif.mem_error, 1'b0);
`endif

        for (int i = 0; i < D0; i++) access0(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, 32'h0, 32'h0);

        access0(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        access0(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        want = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int k = 0; k < WORD_BYTES; k++) check($sformatf("lane%0d", k), 32'(mif.mem_data_out[k]), 32'(want[k]));

        // Load held with a conflicting store request during BUSY and DONE.
        access0(1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        access0(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset two cycles into a store, with a same-cycle request that must drop.
        access0(1'b1, 32'h30, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0);
        mif.mem_req = 1'b1; mif.mem_write_en = 1'b1; mif.mem_addr = 32'h30; mif.mem_data_in = 32'h11223344;
        @(posedge clk); #1;
        e.due = cyc + L0 - 1; e.is_load = 1'b0; e.err = 1'b0; e.dat = '0;
        q0.push_back(e);
        mif.mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; mif.mem_req = 1'b1; mif.mem_write_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; mif.mem_req = 1'b0;
        check_bit("abort_busy", mif.mem_busy, 1'b0);
        check_bit("abort_ready", mif.mem_ready, 1'b0);
        check("abort_dout", mif.mem_data_out, 32'h0);
        repeat (L0 + 1) begin @(posedge clk); #1; end
        access0(1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Addresses alias modulo DEPTH_WORDS*4.
        access0(1'b1, 32'h44, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 32'h0);
        access0(1'b0, 32'h04, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

`ifdef DATA_MEM_ALIGN_CHECK_EN
        access0(1'b1, 32'h12, 32'h99887766, 1'b0, 1'b0, 32'h0, 32'h0);
        access0(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
`endif

        for (int i = 0; i < 150; i++) begin
            access0(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // LATENCY=1 instance: request held continuously, store then load to 0x0.
        mif1.mem_req = 1'b1; mif1.mem_addr = 32'h0;
        for (int r = 0; r < 3; r++) begin
            d = $urandom;
            mif1.mem_write_en = 1'b1; mif1.mem_data_in = d;
            @(posedge clk); #1;
            e.due = cyc + L1 - 1; e.is_load = 1'b0; e.err = 1'b0; e.dat = '0;
            q1.push_back(e);
            @(posedge clk); #1;
            mif1.mem_write_en = 1'b0; mif1.mem_data_in = ~d;
            @(posedge clk); #1;
            e.due = cyc + L1 - 1; e.is_load = 1'b1; e.dat = d;
            q1.push_back(e);
            @(posedge clk); #1;
        end
        mif1.mem_req = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
